instruction_fetch: RTL and testbench

- Produces the instruction stream consumed by the MIPS decode/control stage.
- Owns the program counter and issues single-outstanding word reads to instruction memory over a request/acknowledge handshake.
- Presents each fetched instruction, its opcode field, PC and PC+4 through a valid/ready output buffered for stalls.
- Accepts branch/jump redirects from execute, squashing anything fetched down the wrong path.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/fetch_skid_buffer.sv | 50 +++++
 rtl/instruction_fetch.sv | 89 ++++++++
 tb/tb_instruction_fetch.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode fields used by control, fetch state
// encoding and the fetch buffer entry layout.
package mips_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  localparam logic [5:0] R_TYPE = 6'd0;
  localparam logic [5:0] J      = 6'd2;
  localparam logic [5:0] JAL    = 6'd3;
  localparam logic [5:0] BEQ    = 6'd4;
  localparam logic [5:0] BNE    = 6'd5;
  localparam logic [5:0] ADDI   = 6'd8;
  localparam logic [5:0] LW     = 6'd35;
  localparam logic [5:0] SW     = 6'd43;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry (output + skid) valid/ready buffer of fetched {pc, instr}.
// Upstream only pushes when a slot is guaranteed free.
module fetch_skid_buffer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  input  fetch_entry_t in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output fetch_entry_t out_data,
  output logic         skid_valid
);

  fetch_entry_t skid_data;
  logic         load_out;

  assign load_out = !out_valid || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= {RESET_PC, 32'h0};
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_out) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= in_valid;
        skid_data  <= in_data;
      end else begin
        out_valid <= in_valid;
        // data held when empty so pc_o stays meaningful
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS instruction fetch: PC register, single-outstanding imem handshake,
// redirect/kill handling and a buffered valid/ready instruction output.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [5:0]  opcode_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc_q, addr_q, tgt;
  logic         out_valid, skid_valid, xfer, capture, room;
  fetch_entry_t out_data, cap_data;

  assign tgt        = redirect_pc_i & ~32'h3;
  assign imem_req_o = (state != IDLE);
  assign imem_addr_o = addr_q;
  assign xfer       = out_valid & instr_ready_i;
  assign capture    = (state == REQ) & imem_ack_i & ~redirect_i;
  // buffer drains to empty this edge (before any capture lands)
  assign room       = ~out_valid | (xfer & ~skid_valid);
  assign cap_data   = '{pc: addr_q, instr: imem_rdata_i};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (redirect_i || room) state_nxt = REQ;
      REQ: begin
        if (redirect_i)      state_nxt = imem_ack_i ? REQ : KILL;
        else if (imem_ack_i) state_nxt = room ? REQ : IDLE;
      end
      KILL:    if (imem_ack_i) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // addr_q tracks pc_q except in KILL, where it holds the abandoned address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pc_q   <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (redirect_i) begin
        pc_q <= tgt;
        if (state_nxt != KILL) addr_q <= tgt;
      end else if (capture) begin
        pc_q   <= pc_q + 32'd4;
        addr_q <= pc_q + 32'd4;
      end else if (state == KILL && imem_ack_i) begin
        addr_q <= pc_q;
      end
    end
  end

  fetch_skid_buffer #(.RESET_PC(RESET_PC)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_i),
    .in_valid   (capture),
    .in_data    (cap_data),
    .out_ready  (instr_ready_i),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .skid_valid (skid_valid)
  );

  assign instr_valid_o = out_valid;
  assign instr_o       = out_data.instr;
  assign opcode_o      = out_data.instr[31:26];
  assign pc_o          = out_data.pc;
  assign pc_plus4_o    = out_data.pc + 32'd4;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: scripted timing scenarios plus randomized
// latency/ready/redirect traffic checked against an in-order PC stream model.
module tb_instruction_fetch;
  import mips_pkg::*;

  localparam logic [31:0] RST = 32'h0040_0000;

  logic        clk = 1'b0, reset = 1'b1;
  logic        imem_req_o, imem_ack_i, instr_valid_o, instr_ready_i, redirect_i;
  logic [31:0] imem_addr_o, imem_rdata_i, instr_o, pc_o, pc_plus4_o, redirect_pc_i;
  logic [5:0]  opcode_o;

  int          errors = 0, checks = 0, nxfer = 0;
  logic [31:0] exp_pc = RST;
  int          lat = 0, cur_lat = 0, wait_cnt = 0;
  bit          lat_rand = 1'b0;

  instruction_fetch dut (
    .clk(clk), .reset(reset),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .opcode_o(opcode_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:2], a[31:8] ^ 24'h5A3C1F, 2'b11};
  endfunction

  // memory: ack once the request has waited eff_lat cycles
  int eff_lat;
  assign eff_lat      = lat_rand ? cur_lat : lat;
  assign imem_ack_i   = imem_req_o && (wait_cnt >= eff_lat);
  assign imem_rdata_i = mem_word(imem_addr_o);

  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (imem_req_o && !imem_ack_i) wait_cnt <= wait_cnt + 1;
    else begin
      wait_cnt <= 0;
      if (imem_req_o) cur_lat <= int'($urandom_range(0, 3));
    end
  end

  // one clock: scoreboard the transfer, advance, check address hold
  task automatic cycle();
    logic pend, was_xfer, was_redir;
    logic [31:0] paddr, rtgt, ew;
    pend      = imem_req_o && !imem_ack_i && !reset;
    paddr     = imem_addr_o;
    was_xfer  = instr_valid_o && instr_ready_i;
    was_redir = redirect_i;
    rtgt      = redirect_pc_i & ~32'h3;
    if (was_xfer) begin
      ew = mem_word(exp_pc);
      checks++;
      if (pc_o !== exp_pc) begin
        errors++; $display("FAIL sb_pc: got %h expected %h", pc_o, exp_pc);
      end
      checks++;
      if ({instr_o, opcode_o, pc_plus4_o} !== {ew, ew[31:26], exp_pc + 32'd4}) begin
        errors++;
        $display("FAIL sb_data: got instr %h op %h pc4 %h expected %h %h %h",
                 instr_o, opcode_o, pc_plus4_o, ew, ew[31:26], exp_pc + 32'd4);
      end
    end
    @(posedge clk); #1;
    redirect_i = 1'b0;
    if (was_redir) exp_pc = rtgt;
    else if (was_xfer) begin exp_pc = exp_pc + 32'd4; nxfer++; end
    if (pend && !reset) begin
      checks++;
      if (!imem_req_o || imem_addr_o !== paddr) begin
        errors++;
        $display("FAIL addr_hold: req %b addr %h expected req 1 addr %h", imem_req_o, imem_addr_o, paddr);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; exp_pc = RST;
  endtask

  task automatic test_reset();
    @(posedge clk); #1; @(posedge clk); #1;
    checks++;
    if ({imem_req_o, imem_addr_o, instr_valid_o, instr_o, opcode_o, pc_o, pc_plus4_o} !==
        {1'b0, RST, 1'b0, 32'h0, 6'h0, RST, RST + 32'd4}) begin
      errors++;
      $display("FAIL reset_vals: req %b addr %h v %b instr %h op %h pc %h pc4 %h expected 0 %h 0 0 0 %h %h",
               imem_req_o, imem_addr_o, instr_valid_o, instr_o, opcode_o, pc_o, pc_plus4_o, RST, RST, RST + 32'd4);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] ea, ep, ew;
    lat = 0; lat_rand = 0; instr_ready_i = 1'b1;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      cycle();
      ea = RST + 32'(4 * (k - 1));
      ep = RST + 32'(4 * (k - 2));
      ew = mem_word(ep);
      checks++;
      if (k == 1) begin
        if ({imem_req_o, imem_addr_o, instr_valid_o} !== {1'b1, RST, 1'b0}) begin
          errors++; $display("FAIL zw_first_req: req %b addr %h v %b", imem_req_o, imem_addr_o, instr_valid_o);
        end
      end else if ({imem_req_o, imem_addr_o, instr_valid_o, pc_o, opcode_o} !==
                   {1'b1, ea, 1'b1, ep, ew[31:26]}) begin
        errors++;
        $display("FAIL zw_stream k=%0d: req %b addr %h v %b pc %h op %h expected addr %h pc %h op %h",
                 k, imem_req_o, imem_addr_o, instr_valid_o, pc_o, opcode_o, ea, ep, ew[31:26]);
      end
    end
  endtask

  task automatic test_latency();
    logic ev; logic [31:0] ea, ep;
    lat = 3; lat_rand = 0; instr_ready_i = 1'b1;
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      cycle();
      ev = (k >= 5) && ((k - 5) % 4 == 0);
      ea = RST + 32'(4 * ((k - 1) / 4));
      ep = RST + 32'(4 * ((k - 5) / 4));
      checks++;
      if (instr_valid_o !== ev || imem_req_o !== 1'b1 || imem_addr_o !== ea || (ev && pc_o !== ep)) begin
        errors++;
        $display("FAIL lat3 k=%0d: v %b req %b addr %h pc %h expected v %b addr %h pc %h",
                 k, instr_valid_o, imem_req_o, imem_addr_o, pc_o, ev, ea, ep);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held; int n0;
    lat = 0; lat_rand = 0; instr_ready_i = 1'b1;
    do_reset();
    repeat (4) cycle();
    held = pc_o;
    instr_ready_i = 1'b0;
    for (int s = 0; s < 5; s++) begin
      cycle();
      checks++;
      if (instr_valid_o !== 1'b1 || pc_o !== held) begin
        errors++; $display("FAIL stall_hold s=%0d: v %b pc %h expected 1 %h", s, instr_valid_o, pc_o, held);
      end
    end
    checks++;
    if (imem_req_o !== 1'b0) begin
      errors++; $display("FAIL stall_req: req %b expected 0", imem_req_o);
    end
    instr_ready_i = 1'b1;
    n0 = nxfer;
    repeat (10) cycle();
    checks++;
    if (nxfer - n0 < 8) begin
      errors++; $display("FAIL stall_resume: %0d transfers expected at least 8", nxfer - n0);
    end
  endtask

  task automatic test_redirect_outstanding();
    int n;
    lat = 2; lat_rand = 0; instr_ready_i = 1'b1;
    do_reset();
    cycle();
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0100;
    cycle();
    checks++;
    if ({imem_req_o, imem_addr_o, instr_valid_o} !== {1'b1, RST, 1'b0}) begin
      errors++; $display("FAIL kill_hold: req %b addr %h v %b expected 1 %h 0", imem_req_o, imem_addr_o, instr_valid_o, RST);
    end
    cycle(); cycle();
    checks++;
    if ({imem_req_o, imem_addr_o, instr_valid_o} !== {1'b1, 32'h0040_0100, 1'b0}) begin
      errors++; $display("FAIL kill_retarget: req %b addr %h v %b expected 1 00400100 0", imem_req_o, imem_addr_o, instr_valid_o);
    end
    n = 0;
    while (!instr_valid_o && n < 12) begin cycle(); n++; end
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h0040_0100) begin
      errors++; $display("FAIL kill_first_pc: v %b pc %h expected 1 00400100", instr_valid_o, pc_o);
    end
    // second redirect while killing replaces the target
    lat = 3;
    do_reset();
    cycle();
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0200;
    cycle();
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0300;
    cycle();
    checks++;
    if (imem_addr_o !== RST || instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL kill_rekill: addr %h v %b expected %h 0", imem_addr_o, instr_valid_o, RST);
    end
    n = 0;
    while (!instr_valid_o && n < 12) begin cycle(); n++; end
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h0040_0300) begin
      errors++; $display("FAIL kill_newest: v %b pc %h expected 1 00400300", instr_valid_o, pc_o);
    end
  endtask

  task automatic test_redirect_ack();
    lat = 0; lat_rand = 0; instr_ready_i = 1'b1;
    do_reset();
    repeat (3) cycle();
    redirect_i = 1'b1; redirect_pc_i = 32'h0040_0103;
    cycle();
    checks++;
    if ({imem_req_o, imem_addr_o, instr_valid_o} !== {1'b1, 32'h0040_0100, 1'b0}) begin
      errors++; $display("FAIL redir_ack: req %b addr %h v %b expected 1 00400100 0", imem_req_o, imem_addr_o, instr_valid_o);
    end
    cycle();
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h0040_0100) begin
      errors++; $display("FAIL redir_ack_pc: v %b pc %h expected 1 00400100", instr_valid_o, pc_o);
    end
  endtask

  task automatic test_wrap_and_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    cycle();
    checks++;
    if (imem_addr_o !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_addr: addr %h expected fffffffc", imem_addr_o);
    end
    cycle();
    checks++;
    if ({instr_valid_o, pc_o, pc_plus4_o, imem_addr_o} !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0}) begin
      errors++; $display("FAIL wrap: v %b pc %h pc4 %h addr %h expected 1 fffffffc 0 0",
                         instr_valid_o, pc_o, pc_plus4_o, imem_addr_o);
    end
    lat = 3;
    cycle(); cycle();
    reset = 1'b1;
    #1;
    checks++;
    if ({imem_req_o, imem_addr_o, instr_valid_o, instr_o, opcode_o, pc_o, pc_plus4_o} !==
        {1'b0, RST, 1'b0, 32'h0, 6'h0, RST, RST + 32'd4}) begin
      errors++;
      $display("FAIL mid_reset: req %b addr %h v %b instr %h op %h pc %h pc4 %h",
               imem_req_o, imem_addr_o, instr_valid_o, instr_o, opcode_o, pc_o, pc_plus4_o);
    end
  endtask

  task automatic test_random();
    int n0;
    lat_rand = 1'b1;
    do_reset();
    n0 = nxfer;
    for (int i = 0; i < 800; i++) begin
      instr_ready_i = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) begin
        redirect_i = 1'b1;
        redirect_pc_i = (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : RST) + 32'($urandom_range(0, 63));
      end
      cycle();
    end
    checks++;
    if (nxfer - n0 < 50) begin
      errors++; $display("FAIL rand_progress: %0d transfers expected at least 50", nxfer - n0);
    end
  endtask

  initial begin
    instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect_outstanding();
    test_redirect_ack();
    test_wrap_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
